// File: rtl/retire_order_pkg.sv
// Shared encodings and bundle types for the dual-issue steer/retire pair.
// Covers instruction width, NOP word, pipe codes and the writeback slot bundle.
`timescale 1ns/1ps
package retire_order_pkg;

  localparam int INST_WIDTH = 32;
  localparam logic [INST_WIDTH-1:0] NOP_INSTRUCTION = 32'h0000_0013;
  localparam int OPCODE_MSB = 6;
  localparam int OPCODE_LSB = 0;

  localparam int PIPE_BITS = 2;
  localparam logic [PIPE_BITS-1:0] PIPE_NONE = 2'd0;
  localparam logic [PIPE_BITS-1:0] PIPE_0    = 2'd1;
  localparam logic [PIPE_BITS-1:0] PIPE_1    = 2'd2;
  localparam logic [PIPE_BITS-1:0] PIPE_ANY  = 2'd3;

  localparam int RETIRE_COUNT_WIDTH = 32;

  typedef struct packed {
    logic [INST_WIDTH-1:0] inst;
    logic                  wen;
    logic [4:0]            waddr;
    logic [31:0]           result;
  } slot_t;

  function automatic logic is_nop(input logic [INST_WIDTH-1:0] inst);
    return inst == NOP_INSTRUCTION;
  endfunction

endpackage

// File: rtl/retire_order_first_delay_line.sv
// Carries the steer swap flag down to writeback in lockstep with the pipe.
// Holds on stall, clears on flush so killed pairs cannot swap later ones.
`timescale 1ns/1ps
module first_delay_line #(
  parameter int DEPTH = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  input  logic din,
  output logic dout
);

  logic [DEPTH-1:0] q;
  logic [DEPTH-1:0] nxt;

  always_comb begin
    nxt = (q << 1) | DEPTH'(din);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (en) begin
      if (clr) q <= '0;
      else     q <= nxt;
    end
  end

  assign dout = q[DEPTH-1];

endmodule

// File: rtl/retire_order.sv
// Restores program order of a dual-issue pair at writeback, compacts NOP
// bubbles and presents up to two ordered retirements per cycle.
`timescale 1ns/1ps
module retire_order
  import retire_order_pkg::*;
#(
  parameter int PIPE_DEPTH  = 3,
  parameter int COUNT_WIDTH = RETIRE_COUNT_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   stall,
  input  logic                   flush,
  input  logic                   first_in,
  input  logic [INST_WIDTH-1:0]  pipe0_inst_wb,
  input  logic                   pipe0_wen_wb,
  input  logic [4:0]             pipe0_waddr_wb,
  input  logic [31:0]            pipe0_result_wb,
  input  logic [INST_WIDTH-1:0]  pipe1_inst_wb,
  input  logic                   pipe1_wen_wb,
  input  logic [4:0]             pipe1_waddr_wb,
  input  logic [31:0]            pipe1_result_wb,
  output logic                   ret0_valid,
  output logic [INST_WIDTH-1:0]  ret0_inst,
  output logic                   ret0_wen,
  output logic [4:0]             ret0_waddr,
  output logic [31:0]            ret0_result,
  output logic                   ret1_valid,
  output logic [INST_WIDTH-1:0]  ret1_inst,
  output logic                   ret1_wen,
  output logic [4:0]             ret1_waddr,
  output logic [31:0]            ret1_result,
  output logic [COUNT_WIDTH-1:0] retire_count
);

  logic first_wb;
  logic advance;

  assign advance = ~stall;

  first_delay_line #(
    .DEPTH(PIPE_DEPTH)
  ) u_first_dl (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (advance),
    .clr  (flush),
    .din  (first_in),
    .dout (first_wb)
  );

  slot_t s0, s1, older, younger;
  slot_t r0_d, r1_d;
  logic  ov, yv, r0v_d, r1v_d;

  always_comb begin
    s0 = '{pipe0_inst_wb, pipe0_wen_wb, pipe0_waddr_wb, pipe0_result_wb};
    s1 = '{pipe1_inst_wb, pipe1_wen_wb, pipe1_waddr_wb, pipe1_result_wb};
    s0.wen = pipe0_wen_wb & ~is_nop(pipe0_inst_wb);
    s1.wen = pipe1_wen_wb & ~is_nop(pipe1_inst_wb);
    older   = first_wb ? s1 : s0;
    younger = first_wb ? s0 : s1;
    ov = ~is_nop(older.inst);
    yv = ~is_nop(younger.inst);
    // a lone younger slides into ret0 so ret1 never outruns ret0
    r0_d  = (!ov && yv) ? younger : older;
    r1_d  = younger;
    r0v_d = ov | yv;
    r1v_d = ov & yv;
  end

  slot_t                  ret0_q, ret1_q;
  logic                   v0_q, v1_q;
  logic [COUNT_WIDTH-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ret0_q <= '0;
      ret1_q <= '0;
      v0_q   <= 1'b0;
      v1_q   <= 1'b0;
      cnt_q  <= '0;
    end else if (stall || flush) begin
      v0_q <= 1'b0;
      v1_q <= 1'b0;
    end else begin
      ret0_q <= r0_d;
      ret1_q <= r1_d;
      v0_q   <= r0v_d;
      v1_q   <= r1v_d;
      cnt_q  <= cnt_q + COUNT_WIDTH'(r0v_d) + COUNT_WIDTH'(r1v_d);
    end
  end

  assign ret0_valid   = v0_q;
  assign ret0_inst    = ret0_q.inst;
  assign ret0_wen     = ret0_q.wen;
  assign ret0_waddr   = ret0_q.waddr;
  assign ret0_result  = ret0_q.result;
  assign ret1_valid   = v1_q;
  assign ret1_inst    = ret1_q.inst;
  assign ret1_wen     = ret1_q.wen;
  assign ret1_waddr   = ret1_q.waddr;
  assign ret1_result  = ret1_q.result;
  assign retire_count = cnt_q;

endmodule

// File: tb/tb_retire_order.sv
// Bench for retire_order: directed scenarios plus randomized traffic
// checked against an issue-history reference model.
`timescale 1ns/1ps
module tb_retire_order;
  import retire_order_pkg::*;

  localparam int PD = 3;
  localparam int CW = 4;

  localparam logic [31:0] ADD = 32'h0020_8033;
  localparam logic [31:0] LWA = 32'h0000_a103;
  localparam logic [31:0] LWB = 32'h0040_a183;
  localparam logic [31:0] SW  = 32'h0020_a023;
  localparam logic [31:0] CMP = 32'h0020_a1b3;
  localparam logic [31:0] NOP = NOP_INSTRUCTION;

  logic clk = 1'b0;
  logic rst_n, stall, flush, first_in;
  logic [INST_WIDTH-1:0] p_inst [2];
  logic p_wen [2];
  logic [4:0] p_waddr [2];
  logic [31:0] p_result [2];

  logic ret0_valid, ret0_wen, ret1_valid, ret1_wen;
  logic [INST_WIDTH-1:0] ret0_inst, ret1_inst;
  logic [4:0] ret0_waddr, ret1_waddr;
  logic [31:0] ret0_result, ret1_result;
  logic [CW-1:0] retire_count;

  int checks = 0;
  int failures = 0;

  retire_order #(.PIPE_DEPTH(PD), .COUNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .first_in(first_in),
    .pipe0_inst_wb(p_inst[0]), .pipe0_wen_wb(p_wen[0]),
    .pipe0_waddr_wb(p_waddr[0]), .pipe0_result_wb(p_result[0]),
    .pipe1_inst_wb(p_inst[1]), .pipe1_wen_wb(p_wen[1]),
    .pipe1_waddr_wb(p_waddr[1]), .pipe1_result_wb(p_result[1]),
    .ret0_valid(ret0_valid), .ret0_inst(ret0_inst), .ret0_wen(ret0_wen),
    .ret0_waddr(ret0_waddr), .ret0_result(ret0_result),
    .ret1_valid(ret1_valid), .ret1_inst(ret1_inst), .ret1_wen(ret1_wen),
    .ret1_waddr(ret1_waddr), .ret1_result(ret1_result),
    .retire_count(retire_count)
  );

  always #5 clk = ~clk;

  // reference model: per advancing cycle, what was issued and was it flushed
  bit h_first [$];
  bit h_flush [$];
  logic ev0, ev1;
  slot_t e0, e1;
  logic [CW-1:0] ecnt;

  function automatic bit m_first_wb();
    int n = h_first.size();
    int j;
    if (n < PD) return 1'b0;
    j = n - PD;
    if (!h_first[j]) return 1'b0;
    for (int k = j; k < n; k++) if (h_flush[k]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic m_reset();
    h_first.delete();
    h_flush.delete();
    ev0 = 1'b0; ev1 = 1'b0;
    e0 = '0; e1 = '0;
    ecnt = '0;
  endtask

  task automatic advance();
    slot_t s [2];
    int o, y;
    bit vo, vy;
    if (stall) begin
      ev0 = 1'b0; ev1 = 1'b0;
    end else begin
      if (flush) begin
        ev0 = 1'b0; ev1 = 1'b0;
      end else begin
        o = m_first_wb() ? 1 : 0;
        y = 1 - o;
        for (int i = 0; i < 2; i++)
          s[i] = '{p_inst[i], p_wen[i], p_waddr[i], p_result[i]};
        vo = (p_inst[o] !== NOP);
        vy = (p_inst[y] !== NOP);
        ev0 = vo || vy;
        ev1 = vo && vy;
        if (vo) begin e0 = s[o]; e1 = s[y]; end
        else if (vy) e0 = s[y];
        ecnt = ecnt + CW'(ev0) + CW'(ev1);
      end
      h_first.push_back(first_in);
      h_flush.push_back(flush);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_slot(input int i, input logic [31:0] inst,
                          input logic wen, input logic [4:0] wa,
                          input logic [31:0] res);
    p_inst[i] = inst; p_wen[i] = wen; p_waddr[i] = wa; p_result[i] = res;
  endtask

  task automatic set_pair(input logic [31:0] i0, input logic [31:0] i1);
    set_slot(0, i0, i0 != SW, 5'($urandom_range(0, 31)), $urandom);
    set_slot(1, i1, i1 != SW, 5'($urandom_range(0, 31)), $urandom);
  endtask

  function automatic logic [31:0] rand_inst();
    case ($urandom_range(0, 6))
      0, 1:    return NOP;
      2:       return ADD;
      3:       return LWA;
      4:       return SW;
      5:       return CMP;
      default: return $urandom;
    endcase
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0; first_in = 1'b0;
    set_pair(NOP, NOP);
    m_reset();
    #2;
    checks++;
    if ({ret0_valid, ret1_valid} !== 2'b00) begin
      failures++;
      $display("FAIL reset_valid got=%b want=00", {ret0_valid, ret1_valid});
    end
    checks++;
    if (retire_count !== '0) begin
      failures++;
      $display("FAIL reset_count got=%0d want=0", retire_count);
    end
    checks++;
    if ({ret0_inst, ret0_wen, ret1_inst, ret1_wen, ret0_result} !== '0) begin
      failures++;
      $display("FAIL reset_data got=%h/%h want=0", ret0_inst, ret1_inst);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_in_order();
    logic [CW-1:0] c0;
    first_in = 1'b0;
    set_pair(NOP, NOP);
    repeat (PD) advance();
    c0 = ecnt;
    set_slot(0, ADD, 1'b1, 5'd1, 32'd5);
    set_slot(1, LWA, 1'b1, 5'd2, 32'd9);
    advance();
    checks++;
    if ({ret0_valid, ret0_inst, ret0_waddr, ret0_result} !== {1'b1, ADD, 5'd1, 32'd5}) begin
      failures++;
      $display("FAIL in_order_ret0 got=%b/%h/%0d/%0d want=1/%h/1/5",
               ret0_valid, ret0_inst, ret0_waddr, ret0_result, ADD);
    end
    checks++;
    if ({ret1_valid, ret1_inst, ret1_waddr, ret1_result} !== {1'b1, LWA, 5'd2, 32'd9}) begin
      failures++;
      $display("FAIL in_order_ret1 got=%b/%h/%0d/%0d want=1/%h/2/9",
               ret1_valid, ret1_inst, ret1_waddr, ret1_result, LWA);
    end
    checks++;
    if (retire_count !== CW'(c0 + 2)) begin
      failures++;
      $display("FAIL in_order_count got=%0d want=%0d", retire_count, CW'(c0 + 2));
    end
  endtask

  task automatic test_swapped();
    set_pair(NOP, NOP);
    first_in = 1'b1;
    advance();
    first_in = 1'b0;
    repeat (PD - 1) advance();
    set_slot(0, CMP, 1'b1, 5'd3, 32'd1);
    set_slot(1, SW, 1'b0, 5'd0, 32'd77);
    advance();
    checks++;
    if ({ret0_valid, ret0_inst, ret0_wen} !== {1'b1, SW, 1'b0}) begin
      failures++;
      $display("FAIL swapped_ret0 got=%b/%h/%b want=1/%h/0",
               ret0_valid, ret0_inst, ret0_wen, SW);
    end
    checks++;
    if ({ret1_valid, ret1_inst, ret1_wen, ret1_waddr} !== {1'b1, CMP, 1'b1, 5'd3}) begin
      failures++;
      $display("FAIL swapped_ret1 got=%b/%h/%b/%0d want=1/%h/1/3",
               ret1_valid, ret1_inst, ret1_wen, ret1_waddr, CMP);
    end
  endtask

  task automatic test_split();
    logic [CW-1:0] c0;
    set_pair(NOP, NOP);
    first_in = 1'b1;
    advance();
    first_in = 1'b0;
    repeat (PD - 1) advance();
    c0 = ecnt;
    set_slot(0, NOP, 1'b1, 5'd7, 32'd0);
    set_slot(1, LWA, 1'b1, 5'd2, 32'hA);
    advance();
    checks++;
    if ({ret0_valid, ret0_inst, ret0_result, ret1_valid} !== {1'b1, LWA, 32'hA, 1'b0}) begin
      failures++;
      $display("FAIL split_first got=%b/%h/%h v1=%b want=1/%h/a v1=0",
               ret0_valid, ret0_inst, ret0_result, ret1_valid, LWA);
    end
    set_slot(0, NOP, 1'b1, 5'd7, 32'd0);
    set_slot(1, LWB, 1'b1, 5'd3, 32'hB);
    advance();
    checks++;
    if ({ret0_valid, ret0_inst, ret0_result, ret1_valid} !== {1'b1, LWB, 32'hB, 1'b0}) begin
      failures++;
      $display("FAIL split_second got=%b/%h/%h v1=%b want=1/%h/b v1=0",
               ret0_valid, ret0_inst, ret0_result, ret1_valid, LWB);
    end
    checks++;
    if (retire_count !== CW'(c0 + 2)) begin
      failures++;
      $display("FAIL split_count got=%0d want=%0d", retire_count, CW'(c0 + 2));
    end
  endtask

  task automatic test_stall();
    logic [CW-1:0] c0;
    for (int i = 0; i < 4; i++) begin
      first_in = 1'($urandom_range(0, 1));
      set_pair(rand_inst(), rand_inst());
      advance();
    end
    c0 = ecnt;
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      first_in = 1'($urandom_range(0, 1));
      set_pair(ADD, LWA);
      advance();
      checks++;
      if ({ret0_valid, ret1_valid} !== 2'b00 || retire_count !== c0) begin
        failures++;
        $display("FAIL stall_hold cyc=%0d got v=%b%b cnt=%0d want v=00 cnt=%0d",
                 i, ret0_valid, ret1_valid, retire_count, c0);
      end
    end
    stall = 1'b0;
    for (int i = 0; i < PD + 2; i++) begin
      first_in = 1'($urandom_range(0, 1));
      set_pair(ADD, CMP);
      advance();
      checks++;
      if ({ret0_valid, ret1_valid} !== {ev0, ev1} || retire_count !== ecnt
          || {ret0_inst, ret0_waddr} !== {e0.inst, e0.waddr}
          || {ret1_inst, ret1_waddr} !== {e1.inst, e1.waddr}) begin
        failures++;
        $display("FAIL stall_release cyc=%0d got %h/%h cnt=%0d want %h/%h cnt=%0d",
                 i, ret0_inst, ret1_inst, retire_count, e0.inst, e1.inst, ecnt);
      end
    end
  endtask

  task automatic test_flush();
    logic [CW-1:0] c0;
    first_in = 1'b1;
    set_pair(NOP, NOP);
    repeat (PD) advance();
    c0 = ecnt;
    flush = 1'b1;
    set_pair(ADD, LWA);
    advance();
    flush = 1'b0;
    checks++;
    if ({ret0_valid, ret1_valid} !== 2'b00 || retire_count !== c0) begin
      failures++;
      $display("FAIL flush_kill got v=%b%b cnt=%0d want v=00 cnt=%0d",
               ret0_valid, ret1_valid, retire_count, c0);
    end
    for (int i = 0; i < PD; i++) begin
      set_pair(ADD, LWA);
      advance();
      checks++;
      if ({ret0_valid, ret0_inst, ret1_valid, ret1_inst} !== {1'b1, ADD, 1'b1, LWA}) begin
        failures++;
        $display("FAIL flush_order cyc=%0d got %h/%h want %h/%h",
                 i, ret0_inst, ret1_inst, ADD, LWA);
      end
    end
    first_in = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      stall = ($urandom_range(0, 9) == 0);
      flush = ($urandom_range(0, 19) == 0);
      first_in = 1'($urandom_range(0, 1));
      set_pair(rand_inst(), rand_inst());
      if ($urandom_range(0, 7) == 0) set_slot(1, p_inst[0], 1'b1, p_waddr[0], $urandom);
      advance();
      checks++;
      if ({ret0_valid, ret1_valid} !== {ev0, ev1}) begin
        failures++;
        $display("FAIL rand_valid cyc=%0d got=%b%b want=%b%b",
                 i, ret0_valid, ret1_valid, ev0, ev1);
      end
      checks++;
      if (retire_count !== ecnt) begin
        failures++;
        $display("FAIL rand_count cyc=%0d got=%0d want=%0d", i, retire_count, ecnt);
      end
      if (ev0) begin
        checks++;
        if ({ret0_inst, ret0_wen, ret0_waddr, ret0_result} !== e0) begin
          failures++;
          $display("FAIL rand_ret0 cyc=%0d got=%h want=%h", i,
                   {ret0_inst, ret0_wen, ret0_waddr, ret0_result}, e0);
        end
      end
      if (ev1) begin
        checks++;
        if ({ret1_inst, ret1_wen, ret1_waddr, ret1_result} !== e1) begin
          failures++;
          $display("FAIL rand_ret1 cyc=%0d got=%h want=%h", i,
                   {ret1_inst, ret1_wen, ret1_waddr, ret1_result}, e1);
        end
      end
    end
    stall = 1'b0;
    flush = 1'b0;
  endtask

  task automatic test_reset_mid();
    first_in = 1'b1;
    set_pair(ADD, LWA);
    repeat (PD) advance();
    rst_n = 1'b0;
    #0.5;
    checks++;
    if ({ret0_valid, ret1_valid} !== 2'b00 || retire_count !== '0) begin
      failures++;
      $display("FAIL reset_mid got v=%b%b cnt=%0d want v=00 cnt=0",
               ret0_valid, ret1_valid, retire_count);
    end
    #0.5;
    rst_n = 1'b1;
    m_reset();
    set_slot(0, CMP, 1'b1, 5'd4, 32'd1);
    set_slot(1, SW, 1'b0, 5'd0, 32'd2);
    advance();
    checks++;
    if ({ret0_inst, ret1_inst, retire_count} !== {CMP, SW, CW'(2)}) begin
      failures++;
      $display("FAIL reset_first_pair got %h/%h cnt=%0d want %h/%h cnt=2",
               ret0_inst, ret1_inst, retire_count, CMP, SW);
    end
    first_in = 1'b0;
  endtask

  task automatic test_wrap();
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    m_reset();
    first_in = 1'b0;
    for (int i = 0; i < 7; i++) begin
      set_pair(ADD, LWA);
      advance();
    end
    set_pair(ADD, NOP);
    advance();
    checks++;
    if (retire_count !== CW'(15)) begin
      failures++;
      $display("FAIL wrap_preload got=%0d want=15", retire_count);
    end
    set_pair(ADD, LWA);
    advance();
    checks++;
    if (retire_count !== CW'(1)) begin
      failures++;
      $display("FAIL wrap_count got=%0d want=1", retire_count);
    end
  endtask

  initial begin
    test_reset();
    test_in_order();
    test_swapped();
    test_split();
    test_stall();
    test_flush();
    test_random();
    test_reset_mid();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
